mp_calc_sequencer: RTL and testbench
====================================

# mp_calc_sequencer

Command sequencer that drives `MP_calculator` from the initiator side. It buffers operand/opcode commands in a small FIFO and issues each one to the calculator with a one-cycle `compute` pulse. It then waits a fixed opcode-dependent latency, captures `out`/`im`, and returns them on a valid/ready result port. It sits between a host/control block and the calculator, replacing hand-timed `compute` strobes.

## Interface
- `DEPTH`, 4 — command FIFO entries (power of two, ≥2)
- `LAT_BASIC`, 8 — wait cycles after `compute` for opcodes 0–5
- `LAT_EXT`, 96 — wait cycles after `compute` for opcodes ≥6
- `clk  in  1` — single clock, rising edge
- `reset  in  1` — asynchronous, active-low; clears all state
- `cmd_valid  in  1` — host command present
- `cmd_ready  out  1` — FIFO not full
- `cmd_opcode  in  8`, `cmd_A`/`cmd_B`/`cmd_C`/`cmd_D  in  16` — command fields
- `calc_A`/`calc_B`/`calc_C`/`calc_D  out  16`, `calc_opcode  out  8` — to calculator
- `calc_compute  out  1` — one-cycle start strobe to calculator
- `calc_out  in  16`, `calc_im  in  16` — calculator results
- `res_valid  out  1`, `res_ready  in  1` — result handshake
- `res_out  out  16`, `res_im  out  16`, `res_opcode  out  8`, `res_err  out  1` — returned result

## Operation
- FIFO: 72-bit entries; push when `cmd_valid && cmd_ready`; pop only in IDLE. Pointers are one bit wider than the index and wrap modulo 2·DEPTH. Push and pop in the same cycle are both honoured, and the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the `calc_*` operand registers, load the counter with LAT_BASIC (opcode ≤5) or LAT_EXT (opcode ≥6), and go to ISSUE.
  - ISSUE: `calc_compute`=1 for exactly this cycle; go to WAIT.
  - WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, latch `calc_out`/`calc_im`/opcode into the `res_*` registers, set `res_valid`, and go to HOLD.
  - HOLD: hold `res_*` stable. On `res_valid && res_ready`, clear `res_valid` and go to IDLE.
- `calc_*` operands stay stable from ISSUE through the capture edge, and keep their last value afterwards.
- Counter width is `$clog2(max(LAT_BASIC,LAT_EXT)+1)`. No arithmetic is done on data; results pass through unmodified.
- Only one command is outstanding at the calculator at a time.
- Reset asserted (low) at any point, including mid-WAIT:
  - FIFO empties and FSM goes to IDLE immediately.
  - `calc_compute`, `res_valid` and `res_err` drop to 0 asynchronously.
  - The in-flight result is discarded.
- Reset values:
  - `cmd_ready`=1 once reset deasserts (0 while `reset` is low).
  - All `calc_*`=0, `res_*`=0, `res_valid`=0.

## Timing
- Command accepted at edge k with the FSM in IDLE and the FIFO empty:
  - FSM enters ISSUE at edge k+2, so `calc_compute` is high for one cycle starting at edge k+2.
  - WAIT spans LAT cycles. `res_valid` rises at edge k+3+LAT.
- Back-to-back commands: next ISSUE occurs no earlier than 2 cycles after the result handshake edge (return to IDLE, then ISSUE).
- `res_ready` held high: throughput is one command per LAT+4 cycles.
- `cmd_ready` falls in the cycle after the DEPTH-th unpopped push. It rises in the cycle after a pop from a full FIFO.

## Configuration
- `MP_SEQ_OPCHECK_EN` defined:
  - Opcode >9 is illegal. In IDLE it is popped, but no ISSUE or WAIT occurs and `calc_compute` stays 0.
  - FSM goes straight to HOLD with `res_err`=1, `res_out`=`res_im`=0, and `res_opcode`=the offending opcode. `res_valid` rises one edge after the pop.
- `MP_SEQ_OPCHECK_EN` undefined: every opcode is issued normally, opcodes >9 use LAT_EXT, and `res_err` is tied 0.

## Test plan
- Reset, then push {op 0, A=2, B=2} with a calculator model: `calc_compute` pulses one cycle, and `res_valid` rises after LAT_BASIC+1 cycles with `res_out`=4.
- Push {op 1, A=10, B=3}, then {op 3, A=8, B=2}, with `res_ready`=1: results 7 then 4 arrive in order, each in HOLD for exactly one cycle.
- Fill the FIFO: push 6 commands with `res_ready`=0.
  - `cmd_ready` goes low after 4 commands are stored (one is already at the calculator).
  - Releasing `res_ready` drains all 5 accepted commands in order with no loss.
- Push op 8 (A=128, B=2) and hold `res_ready`=0 for 20 cycles after `res_valid`: `res_*` stay stable and no new `calc_compute` occurs.
- Pull `reset` low 10 cycles into WAIT with 2 commands queued: all outputs clear immediately, and after release nothing issues until a new push.
- With `MP_SEQ_OPCHECK_EN`, push op 12: no `calc_compute`, and `res_err`=1, `res_opcode`=12 one edge after the pop. Without the macro, op 12 issues and waits LAT_EXT.

Source files
------------

// File: rtl/mp_calc_sequencer.sv
// Command sequencer for MP_calculator: buffers commands, issues them one at a time with a
// compute strobe, waits a fixed opcode latency and returns the result. Option: MP_SEQ_OPCHECK_EN.
module mp_calc_sequencer #(
   parameter int DEPTH     = 4,
   parameter int LAT_BASIC = 8,
   parameter int LAT_EXT   = 96
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [15:0] cmd_A,
   input  logic [15:0] cmd_B,
   input  logic [15:0] cmd_C,
   input  logic [15:0] cmd_D,
   output logic [15:0] calc_A,
   output logic [15:0] calc_B,
   output logic [15:0] calc_C,
   output logic [15:0] calc_D,
   output logic [7:0]  calc_opcode,
   output logic        calc_compute,
   input  logic [15:0] calc_out,
   input  logic [15:0] calc_im,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_out,
   output logic [15:0] res_im,
   output logic [7:0]  res_opcode,
   output logic        res_err
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LAT_MAX = (LAT_BASIC > LAT_EXT) ? LAT_BASIC : LAT_EXT;
   localparam int CW      = $clog2(LAT_MAX + 1);

   localparam logic [AW:0]   FULL_FILL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
   localparam logic [CW-1:0] CNT_BASIC = CW'(LAT_BASIC);
   localparam logic [CW-1:0] CNT_EXT   = CW'(LAT_EXT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [15:0] d;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   // ---------------- command FIFO ----------------
   cmd_t        mem_q [DEPTH];
   cmd_t        rd_data_q;
   cmd_t        cmd_in;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] fill;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   assign cmd_in    = {cmd_opcode, cmd_A, cmd_B, cmd_C, cmd_D};
   assign fill      = wr_ptr_q - rd_ptr_q;
   assign full      = (fill == FULL_FILL);
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign cmd_ready = reset & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign wr_ptr_d  = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
   assign rd_ptr_d  = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   // Storage and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
      end
      if (pop) begin
         rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // ---------------- sequencer FSM ----------------
   state_t        state_q, state_d;
   logic          rd_pend_q, rd_pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   cmd_t          calc_q, calc_d;
   logic [15:0]   res_out_q, res_out_d;
   logic [15:0]   res_im_q, res_im_d;
   logic [7:0]    res_op_q, res_op_d;
   logic          res_valid_q, res_valid_d;
   logic          res_err_q, res_err_d;
   logic          op_illegal;

`ifdef MP_SEQ_OPCHECK_EN
   assign op_illegal = (rd_data_q.op > 8'd9);
`else
   assign op_illegal = 1'b0;
`endif

   // IDLE spends one cycle popping into the read register and one cycle loading the operands.
   always_comb begin
      state_d     = state_q;
      rd_pend_d   = rd_pend_q;
      cnt_d       = cnt_q;
      calc_d      = calc_q;
      res_out_d   = res_out_q;
      res_im_d    = res_im_q;
      res_op_d    = res_op_q;
      res_valid_d = res_valid_q;
      res_err_d   = res_err_q;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_pend_q) begin
               rd_pend_d = 1'b0;
               if (op_illegal) begin
                  res_out_d   = '0;
                  res_im_d    = '0;
                  res_op_d    = rd_data_q.op;
                  res_err_d   = 1'b1;
                  res_valid_d = 1'b1;
                  state_d     = S_HOLD;
               end else begin
                  calc_d  = rd_data_q;
                  cnt_d   = (rd_data_q.op <= 8'd5) ? CNT_BASIC : CNT_EXT;
                  state_d = S_ISSUE;
               end
            end else if (!empty) begin
               pop       = 1'b1;
               rd_pend_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               res_out_d   = calc_out;
               res_im_d    = calc_im;
               res_op_d    = calc_q.op;
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               res_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rd_pend_q   <= 1'b0;
         cnt_q       <= '0;
         calc_q      <= '0;
         res_out_q   <= '0;
         res_im_q    <= '0;
         res_op_q    <= '0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_pend_q   <= rd_pend_d;
         cnt_q       <= cnt_d;
         calc_q      <= calc_d;
         res_out_q   <= res_out_d;
         res_im_q    <= res_im_d;
         res_op_q    <= res_op_d;
         res_valid_q <= res_valid_d;
         res_err_q   <= res_err_d;
      end
   end

   assign calc_compute = (state_q == S_ISSUE);
   assign calc_opcode  = calc_q.op;
   assign calc_A       = calc_q.a;
   assign calc_B       = calc_q.b;
   assign calc_C       = calc_q.c;
   assign calc_D       = calc_q.d;
   assign res_valid    = res_valid_q;
   assign res_out      = res_out_q;
   assign res_im       = res_im_q;
   assign res_opcode   = res_op_q;
   assign res_err      = res_err_q;

endmodule

// File: tb/tb_mp_calc_sequencer.sv
// Bench for mp_calc_sequencer: directed and random commands against a calculator model
// and a queue-based scoreboard of expected results and latencies.
module tb_mp_calc_sequencer;

   localparam int DEPTH     = 4;
   localparam int LAT_BASIC = 8;
   localparam int LAT_EXT   = 96;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [15:0] d;
   } cmd_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode = '0;
   logic [15:0] cmd_A = '0, cmd_B = '0, cmd_C = '0, cmd_D = '0;
   logic [15:0] calc_A, calc_B, calc_C, calc_D;
   logic [7:0]  calc_opcode;
   logic        calc_compute;
   logic [15:0] calc_out, calc_im;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_out, res_im;
   logic [7:0]  res_opcode;
   logic        res_err;

   int   errors = 0;
   int   checks = 0;
   int   n_compute = 0;
   cmd_t exp_q[$];
   logic [15:0] last_out;

   mp_calc_sequencer #(.DEPTH(DEPTH), .LAT_BASIC(LAT_BASIC), .LAT_EXT(LAT_EXT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_C(cmd_C), .cmd_D(cmd_D),
      .calc_A(calc_A), .calc_B(calc_B), .calc_C(calc_C), .calc_D(calc_D),
      .calc_opcode(calc_opcode), .calc_compute(calc_compute),
      .calc_out(calc_out), .calc_im(calc_im),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_out(res_out), .res_im(res_im), .res_opcode(res_opcode), .res_err(res_err)
   );

   always #5 clk = ~clk;

   // Calculator stand-in: results follow its operand inputs combinationally.
   function automatic logic [15:0] f_out(input logic [7:0] op, input logic [15:0] a, b, c, d);
      case (op)
         8'd0:    return a + b;
         8'd1:    return a - b;
         8'd2:    return a * b;
         8'd3:    return (b == 16'd0) ? 16'hFFFF : a / b;
         default: return a ^ b ^ c ^ d ^ {8'h00, op};
      endcase
   endfunction

   function automatic logic [15:0] f_im(input logic [15:0] a, b, c, d);
      return {a[7:0], b[7:0]} ^ (c + d);
   endfunction

   assign calc_out = f_out(calc_opcode, calc_A, calc_B, calc_C, calc_D);
   assign calc_im  = f_im(calc_A, calc_B, calc_C, calc_D);

   always @(posedge clk) if (calc_compute) n_compute <= n_compute + 1;

   function automatic void model(input cmd_t c, output logic [15:0] o, output logic [15:0] im,
                                 output logic err);
`ifdef MP_SEQ_OPCHECK_EN
      if (c.op > 8'd9) begin
         o = '0; im = '0; err = 1'b1;
         return;
      end
`endif
      o   = f_out(c.op, c.a, c.b, c.c, c.d);
      im  = f_im(c.a, c.b, c.c, c.d);
      err = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [7:0] op, input logic [15:0] a, b, c, d, output bit acc);
      cmd_t e;
      cmd_opcode = op; cmd_A = a; cmd_B = b; cmd_C = c; cmd_D = d;
      cmd_valid  = 1'b1;
      acc        = cmd_ready;
      tick();
      cmd_valid  = 1'b0;
      if (acc) begin
         e.op = op; e.a = a; e.b = b; e.c = c; e.d = d;
         exp_q.push_back(e);
      end
      $display("push op=%0d A=%0h B=%0h accepted=%0d", op, a, b, acc);
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!res_valid && n < 400) begin
         tick();
         n++;
      end
      chk("res_valid_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic check_res(input string tag);
      cmd_t c;
      logic [15:0] eo, ei;
      logic ee;
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         model(c, eo, ei, ee);
         last_out = eo;
         chk({tag, "_out"}, 32'(res_out), 32'(eo));
         chk({tag, "_im"}, 32'(res_im), 32'(ei));
         chk({tag, "_opcode"}, 32'(res_opcode), 32'(c.op));
         chk({tag, "_err"}, 32'(res_err), 32'(ee));
         $display("result %s op=%0d out=%0h im=%0h err=%0d", tag, res_opcode, res_out, res_im, res_err);
      end
   endtask

   task automatic ack();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("ack_clears_valid", 32'(res_valid), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n, n0, n1, nacc, pulses, run, maxrun;
      int   t_rise[2];
      logic [15:0] got[2];
      bit   acc, seen;

      // Reset state
      repeat (3) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_compute", 32'(calc_compute), 32'd0);
      chk("rst_calc_A", 32'(calc_A), 32'd0);
      chk("rst_calc_opcode", 32'(calc_opcode), 32'd0);
      chk("rst_res_out", 32'(res_out), 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      reset = 1'b1;
      tick();
      chk("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);

      // Single op 0: compute at k+2, result at k+3+LAT
      n0 = n_compute;
      push(8'd0, 16'd2, 16'd2, 16'd0, 16'd0, acc);
      chk("t1_acc", 32'(acc), 32'd1);
      tick();
      chk("t1_compute_k1", 32'(calc_compute), 32'd0);
      tick();
      chk("t1_compute_k2", 32'(calc_compute), 32'd1);
      chk("t1_calc_A", 32'(calc_A), 32'd2);
      chk("t1_calc_B", 32'(calc_B), 32'd2);
      tick();
      chk("t1_compute_k3", 32'(calc_compute), 32'd0);
      repeat (LAT_BASIC - 1) tick();
      chk("t1_valid_early", 32'(res_valid), 32'd0);
      tick();
      chk("t1_valid_rise", 32'(res_valid), 32'd1);
      chk("t1_out_literal", 32'(res_out), 32'd4);
      check_res("t1");
      chk("t1_compute_count", 32'(n_compute - n0), 32'd1);
      ack();

      // Two back-to-back with res_ready high
      res_ready = 1'b1;
      push(8'd1, 16'd10, 16'd3, 16'd0, 16'd0, acc);
      push(8'd3, 16'd8, 16'd2, 16'd0, 16'd0, acc);
      pulses = 0; run = 0; maxrun = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (res_valid) begin
            run++;
            if (run == 1 && pulses < 2) begin
               got[pulses]    = res_out;
               t_rise[pulses] = i;
               check_res($sformatf("t2_%0d", pulses));
               pulses++;
            end
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
      end
      res_ready = 1'b0;
      chk("t2_pulses", 32'(pulses), 32'd2);
      chk("t2_hold_one_cycle", 32'(maxrun), 32'd1);
      chk("t2_first", 32'(got[0]), 32'd7);
      chk("t2_second", 32'(got[1]), 32'd4);
      chk("t2_spacing", 32'(t_rise[1] - t_rise[0]), 32'(LAT_BASIC + 4));

      // Fill the FIFO with res_ready low
      n0 = n_compute; nacc = 0;
      for (int i = 0; i < 6; i++) begin
         push(8'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), acc);
         if (acc) nacc++;
      end
      chk("t3_accepted", 32'(nacc), 32'd5);
      chk("t3_ready_low", 32'(cmd_ready), 32'd0);
      repeat (5) tick();
      chk("t3_ready_still_low", 32'(cmd_ready), 32'd0);
      chk("t3_one_outstanding", 32'(n_compute - n0), 32'd1);
      for (int i = 0; i < 5; i++) begin
         wait_res(n);
         check_res($sformatf("t3_%0d", i));
         ack();
         if (i == 0) begin
            chk("t3_ready_before_pop", 32'(cmd_ready), 32'd0);
            tick();
            chk("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
         end
      end
      chk("t3_drained", 32'(exp_q.size()), 32'd0);

      // Op 8 held in HOLD
      n0 = n_compute;
      push(8'd8, 16'd128, 16'd2, 16'd0, 16'd0, acc);
      wait_res(n);
      chk("t4_latency", 32'(n), 32'(LAT_EXT + 3));
      check_res("t4");
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!res_valid || res_out !== last_out || res_opcode !== 8'd8) seen = 1'b1;
      end
      chk("t4_hold_stable", 32'(seen), 32'd0);
      chk("t4_hold_out", 32'(res_out), 32'(last_out));
      chk("t4_no_new_compute", 32'(n_compute - n0), 32'd1);
      ack();

      // Reset in the middle of WAIT with two commands queued
      n0 = n_compute;
      push(8'd7, 16'($urandom), 16'($urandom), 16'd0, 16'd0, acc);
      push(8'd1, 16'($urandom), 16'($urandom), 16'd0, 16'd0, acc);
      push(8'd2, 16'($urandom), 16'($urandom), 16'd0, 16'd0, acc);
      repeat (10) tick();
      chk("t5_in_wait", 32'(n_compute - n0), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t5_rst_compute", 32'(calc_compute), 32'd0);
      chk("t5_rst_valid", 32'(res_valid), 32'd0);
      chk("t5_rst_ready", 32'(cmd_ready), 32'd0);
      chk("t5_rst_calc_A", 32'(calc_A), 32'd0);
      chk("t5_rst_res_out", 32'(res_out), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      exp_q.delete();
      n1 = n_compute; seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (res_valid) seen = 1'b1;
      end
      chk("t5_no_result", 32'(seen), 32'd0);
      chk("t5_no_issue", 32'(n_compute - n1), 32'd0);
      chk("t5_ready_back", 32'(cmd_ready), 32'd1);
      push(8'd2, 16'd300, 16'd7, 16'd0, 16'd0, acc);
      wait_res(n);
      chk("t5_new_latency", 32'(n), 32'(LAT_BASIC + 3));
      check_res("t5_new");
      ack();

      // Opcode 12
      n0 = n_compute;
      push(8'd12, 16'h1234, 16'h0042, 16'd5, 16'd6, acc);
`ifdef MP_SEQ_OPCHECK_EN
      tick();
      chk("t6_valid_at_pop", 32'(res_valid), 32'd0);
      tick();
      chk("t6_valid", 32'(res_valid), 32'd1);
      chk("t6_err_literal", 32'(res_err), 32'd1);
      chk("t6_opcode_literal", 32'(res_opcode), 32'd12);
      check_res("t6");
      chk("t6_no_compute", 32'(n_compute - n0), 32'd0);
`else
      wait_res(n);
      chk("t6_latency", 32'(n), 32'(LAT_EXT + 3));
      chk("t6_err_literal", 32'(res_err), 32'd0);
      check_res("t6");
      chk("t6_compute", 32'(n_compute - n0), 32'd1);
`endif
      ack();

      // Random rounds
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            push(8'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), acc);
            chk($sformatf("t7_acc_%0d_%0d", r, i), 32'(acc), 32'd1);
         end
         for (int i = 0; i < 3; i++) begin
            wait_res(n);
            check_res($sformatf("t7_%0d_%0d", r, i));
            repeat ($urandom_range(0, 3)) tick();
            ack();
         end
      end
      chk("t7_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
